// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB refill engine.
// Optional fill counter is enabled with the TLB_FILL_PERF_EN macro.
package tlb_pkg;

    localparam int unsigned ENTRIES     = 8;
    localparam int unsigned VPN_W       = 20;
    localparam int unsigned PFN_W       = 20;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned CNT_W       = 16;

    localparam int unsigned PTE_P       = 0;
    localparam int unsigned PTE_RW      = 1;
    localparam int unsigned PTE_PCD     = 4;
    localparam int unsigned PTE_PFN_LSB = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Byte address of the 4-byte PTE for a VPN; wraps mod 2^32.
    function automatic logic [ADDR_W-1:0] pte_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [VPN_W-1:0]  vpn);
        return base + {10'b0, vpn, 2'b00};
    endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Victim selection: matching valid entry, else lowest invalid entry, else round-robin.
module tlb_victim_sel
    import tlb_pkg::*;
(
    input  logic [ENTRIES-1:0]       entry_v,
    input  logic [ENTRIES*VPN_W-1:0] vp,
    input  logic [VPN_W-1:0]         miss_vpn,
    input  logic [IDX_W-1:0]         rr_ptr,
    output logic [IDX_W-1:0]         victim_c,
    output logic                     use_rr_c
);

    logic             hit;
    logic             free;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;

    always_comb begin
        hit      = 1'b0;
        free     = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && entry_v[i] && (vp[i*VPN_W +: VPN_W] == miss_vpn)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!free && !entry_v[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // A duplicate VPN takes priority so the TLB never holds two copies.
    always_comb begin
        victim_c = rr_ptr;
        use_rr_c = 1'b1;
        if (hit) begin
            victim_c = hit_idx;
            use_rr_c = 1'b0;
        end else if (free) begin
            victim_c = free_idx;
            use_rr_c = 1'b0;
        end
    end

endmodule

// File: rtl/tlb_fill.sv
// TLB refill engine: fetches a PTE on miss, installs it into a victim entry, owns flush.
// Define TLB_FILL_PERF_EN to add the saturating fill_count output.
module tlb_fill
    import tlb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_req,
    input  logic [VPN_W-1:0]         miss_vpn,
    input  logic [ADDR_W-1:0]        ptbr,
    input  logic                     flush,
    output logic                     pte_rd_req,
    output logic [ADDR_W-1:0]        pte_rd_addr,
    input  logic                     pte_rd_ack,
    input  logic [31:0]              pte_rd_data,
    output logic [ENTRIES*VPN_W-1:0] VP,
    output logic [ENTRIES*PFN_W-1:0] PF,
    output logic [ENTRIES-1:0]       entry_v,
    output logic [ENTRIES-1:0]       entry_P,
    output logic [ENTRIES-1:0]       entry_RW,
    output logic [ENTRIES-1:0]       entry_PCD,
    output logic                     fill_busy,
    output logic                     fill_done
`ifdef TLB_FILL_PERF_EN
   ,output logic [CNT_W-1:0]         fill_count
`endif
);

    state_t           state;
    state_t           state_next;
    logic [VPN_W-1:0] vpn_q;
    logic [31:0]      pte_q;
    logic [IDX_W-1:0] victim_q;
    logic             use_rr_q;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] victim_c;
    logic             use_rr_c;

    tlb_victim_sel u_victim_sel (
        .entry_v  (entry_v),
        .vp       (VP),
        .miss_vpn (miss_vpn),
        .rr_ptr   (rr_ptr),
        .victim_c (victim_c),
        .use_rr_c (use_rr_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss_req)   state_next = REQ;
            REQ:     if (pte_rd_ack) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pte_rd_req  <= 1'b0;
            pte_rd_addr <= '0;
            fill_busy   <= 1'b0;
            fill_done   <= 1'b0;
            vpn_q       <= '0;
            pte_q       <= '0;
            victim_q    <= '0;
            use_rr_q    <= 1'b0;
        end else begin
            pte_rd_req <= (state_next == REQ);
            fill_busy  <= (state_next != IDLE);
            fill_done  <= (state == WRITE);
            if (state == IDLE && miss_req) begin
                vpn_q       <= miss_vpn;
                victim_q    <= victim_c;
                use_rr_q    <= use_rr_c;
                pte_rd_addr <= pte_addr(ptbr, miss_vpn);
            end
            if (state == REQ && pte_rd_ack) begin
                pte_q <= pte_rd_data;
            end
        end
    end

    // Entry array; a flush in the WRITE cycle overrides the new valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VP        <= '0;
            PF        <= '0;
            entry_v   <= '0;
            entry_P   <= '0;
            entry_RW  <= '0;
            entry_PCD <= '0;
            rr_ptr    <= '0;
        end else begin
            if (state == WRITE) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (victim_q == IDX_W'(i)) begin
                        VP[i*VPN_W +: VPN_W] <= vpn_q;
                        PF[i*PFN_W +: PFN_W] <= pte_q[PTE_PFN_LSB +: PFN_W];
                        entry_v[i]           <= 1'b1;
                        entry_P[i]           <= pte_q[PTE_P];
                        entry_RW[i]          <= pte_q[PTE_RW];
                        entry_PCD[i]         <= pte_q[PTE_PCD];
                    end
                end
                if (use_rr_q) rr_ptr <= rr_ptr + IDX_W'(1);
            end
            if (flush) entry_v <= '0;
        end
    end

`ifdef TLB_FILL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        fill_count <= '0;
        else if (state == WRITE && fill_count != '1)       fill_count <= fill_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_tlb_fill.sv
// Randomized self-checking bench for tlb_fill against an array-based reference model.
module tb_tlb_fill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_req;
    logic [19:0]  miss_vpn;
    logic [31:0]  ptbr;
    logic         flush;
    logic         pte_rd_req;
    logic [31:0]  pte_rd_addr;
    logic         pte_rd_ack;
    logic [31:0]  pte_rd_data;
    logic [159:0] VP;
    logic [159:0] PF;
    logic [7:0]   entry_v;
    logic [7:0]   entry_P;
    logic [7:0]   entry_RW;
    logic [7:0]   entry_PCD;
    logic         fill_busy;
    logic         fill_done;
`ifdef TLB_FILL_PERF_EN
    logic [15:0]  fill_count;
`endif

    tlb_fill dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .miss_req    (miss_req),
        .miss_vpn    (miss_vpn),
        .ptbr        (ptbr),
        .flush       (flush),
        .pte_rd_req  (pte_rd_req),
        .pte_rd_addr (pte_rd_addr),
        .pte_rd_ack  (pte_rd_ack),
        .pte_rd_data (pte_rd_data),
        .VP          (VP),
        .PF          (PF),
        .entry_v     (entry_v),
        .entry_P     (entry_P),
        .entry_RW    (entry_RW),
        .entry_PCD   (entry_PCD),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done)
`ifdef TLB_FILL_PERF_EN
       ,.fill_count  (fill_count)
`endif
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Reference model: one slot per TLB entry plus the round-robin pointer.
    logic [19:0] m_vp  [8];
    logic [19:0] m_pf  [8];
    bit          m_v   [8];
    bit          m_p   [8];
    bit          m_rw  [8];
    bit          m_pcd [8];
    int          m_rr;
    int          m_count;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_vp[i] = '0; m_pf[i] = '0; m_v[i] = 0; m_p[i] = 0; m_rw[i] = 0; m_pcd[i] = 0;
        end
        m_rr    = 0;
        m_count = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 8; i++) m_v[i] = 0;
    endtask

    task automatic model_install(input logic [19:0] vpn, input logic [31:0] pte,
                                 input bit fl_miss, input bit fl_write);
        int victim;
        victim = -1;
        for (int i = 0; i < 8; i++)
            if (victim < 0 && m_v[i] && m_vp[i] == vpn) victim = i;
        if (victim < 0)
            for (int i = 0; i < 8; i++)
                if (victim < 0 && !m_v[i]) victim = i;
        if (victim < 0) begin
            victim = m_rr;
            m_rr   = (m_rr + 1) % 8;
        end
        if (fl_miss) model_flush();
        m_vp[victim]  = vpn;
        m_pf[victim]  = pte[31:12];
        m_v[victim]   = 1;
        m_p[victim]   = pte[0];
        m_rw[victim]  = pte[1];
        m_pcd[victim] = pte[4];
        if (fl_write) model_flush();
        if (m_count < 65535) m_count++;
    endtask

    task automatic check_entries(input string tag);
        logic [159:0] evp, epf;
        logic [7:0]   ev, ep, erw, epcd;
        for (int i = 0; i < 8; i++) begin
            evp[i*20 +: 20] = m_vp[i];
            epf[i*20 +: 20] = m_pf[i];
            ev[i]   = m_v[i];
            ep[i]   = m_p[i];
            erw[i]  = m_rw[i];
            epcd[i] = m_pcd[i];
        end
        chk({tag, ".VP"},  VP,  evp);
        chk({tag, ".PF"},  PF,  epf);
        chk({tag, ".v"},   160'(entry_v),   160'(ev));
        chk({tag, ".P"},   160'(entry_P),   160'(ep));
        chk({tag, ".RW"},  160'(entry_RW),  160'(erw));
        chk({tag, ".PCD"}, 160'(entry_PCD), 160'(epcd));
`ifdef TLB_FILL_PERF_EN
        chk({tag, ".count"}, 160'(fill_count), 160'(m_count));
`endif
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
        check_entries("flush_idle");
    endtask

    // One complete refill; dly = extra cycles before ack.
    task automatic do_fill(input logic [19:0] vpn, input logic [31:0] pte, input int dly,
                           input bit fl_miss, input bit fl_write, input bit toggle);
        logic [31:0] exp_addr;
        exp_addr = ptbr + (32'(vpn) * 32'd4);
        @(negedge clk);
        miss_req = 1'b1;
        miss_vpn = vpn;
        flush    = fl_miss;
        @(posedge clk); #1;
        miss_req = 1'b0;
        flush    = 1'b0;
        chk("busy_req", 160'(fill_busy), 160'(1));
        chk("rd_req",   160'(pte_rd_req), 160'(1));
        chk("rd_addr",  160'(pte_rd_addr), 160'(exp_addr));
        for (int i = 0; i < dly; i++) begin
            if (toggle) begin
                miss_req = i[0];
                miss_vpn = 20'($urandom);
            end
            @(posedge clk); #1;
            chk("rd_req_hold",  160'(pte_rd_req), 160'(1));
            chk("rd_addr_hold", 160'(pte_rd_addr), 160'(exp_addr));
        end
        miss_req    = 1'b0;
        pte_rd_ack  = 1'b1;
        pte_rd_data = pte;
        @(posedge clk); #1;
        pte_rd_ack  = 1'b0;
        pte_rd_data = $urandom;
        chk("done_early", 160'(fill_done), 160'(0));
        chk("rd_req_drop", 160'(pte_rd_req), 160'(0));
        flush = fl_write;
        @(posedge clk); #1;
        flush = 1'b0;
        model_install(vpn, pte, fl_miss, fl_write);
        chk("fill_done", 160'(fill_done), 160'(1));
        chk("busy_idle", 160'(fill_busy), 160'(0));
        check_entries("fill");
    endtask

    initial begin
        rst_n       = 1'b0;
        miss_req    = 1'b0;
        miss_vpn    = '0;
        ptbr        = 32'h0001_0000;
        flush       = 1'b0;
        pte_rd_ack  = 1'b0;
        pte_rd_data = '0;
        model_reset();
        #12;
        chk("rst_rd_req", 160'(pte_rd_req), 160'(0));
        chk("rst_addr",   160'(pte_rd_addr), 160'(0));
        chk("rst_busy",   160'(fill_busy), 160'(0));
        chk("rst_done",   160'(fill_done), 160'(0));
        check_entries("rst");
        rst_n = 1'b1;

        // Basic fill: address 0x1C000, entry 0 with P/RW/PCD set.
        do_fill(20'h03000, 32'h0000_3013, 0, 0, 0, 0);
        chk("t1_addr", 160'(pte_rd_addr), 160'(32'h0001_C000));
        chk("t1_entry0_pf", 160'(PF[19:0]), 160'(20'h00003));

        // Fill all 8 free slots, then round-robin replacement with wrap.
        do_flush();
        for (int i = 0; i < 8; i++)
            do_fill(20'(i * 32'h1000), $urandom, 0, 0, 0, 0);
        do_fill(20'h0a000, $urandom, 0, 0, 0, 0);
        chk("t2_rr_entry0", 160'(VP[19:0]), 160'(20'h0a000));
        for (int i = 0; i < 8; i++)
            do_fill(20'(32'h0b000 + i * 32'h1000), $urandom, int'($urandom_range(0, 2)), 0, 0, 0);
        chk("t2_wrap_entry0", 160'(VP[19:0]), 160'(20'h12000));

        // Not-present PTE is installed valid; re-miss on a valid VPN reuses its slot.
        do_fill(20'h20000, 32'h0000_B000, 0, 0, 0, 0);
        do_fill(20'h0c000, 32'h0005_5012, 1, 0, 0, 0);

        // Delayed ack with miss_req noise on the input.
        do_fill(20'h21000, $urandom, 5, 0, 0, 1);

        // Flush in the WRITE cycle after 3 valid entries.
        do_flush();
        for (int i = 0; i < 3; i++) do_fill(20'(32'h30000 + i), $urandom, 0, 0, 0, 0);
        do_fill(20'h30010, $urandom, 0, 0, 1, 0);
        chk("t5_v_clear", 160'(entry_v), 160'(0));
        do_fill(20'h30011, $urandom, 1, 1, 0, 0);

        // Address wrap past 2^32.
        ptbr = 32'hFFFF_F000;
        do_fill(20'h00800, $urandom, 0, 0, 0, 0);
        chk("wrap_addr", 160'(pte_rd_addr), 160'(32'h0000_1000));

        // Asynchronous reset in the middle of a request.
        @(negedge clk);
        miss_req = 1'b1;
        miss_vpn = 20'h44444;
        @(posedge clk); #1;
        miss_req = 1'b0;
        chk("pre_rst_req", 160'(pte_rd_req), 160'(1));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_rd_req", 160'(pte_rd_req), 160'(0));
        chk("arst_addr",   160'(pte_rd_addr), 160'(0));
        chk("arst_busy",   160'(fill_busy), 160'(0));
        chk("arst_done",   160'(fill_done), 160'(0));
        check_entries("arst");
        @(negedge clk);
        rst_n = 1'b1;

        // Dangling ack in IDLE must not start anything.
        pte_rd_ack = 1'b1;
        @(posedge clk); #1;
        pte_rd_ack = 1'b0;
        chk("dangling_busy", 160'(fill_busy), 160'(0));
        chk("dangling_req",  160'(pte_rd_req), 160'(0));

        // Random fills from a small VPN pool to hit duplicates, flushes and wraps.
        for (int n = 0; n < 40; n++) begin
            logic [19:0] vpn;
            vpn  = 20'($urandom_range(0, 11)) << 12;
            ptbr = $urandom;
            do_fill(vpn, $urandom, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 14) == 0) do_flush();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
